score_ssd_driver: RTL and testbench

- Takes the 16-bit binary `score` produced by the VGA pixel/game stage and shows it on the board's 4-digit common-anode seven-segment display.
- Converts `score` to BCD with a sequential shift-and-add-3 converter (16 shift cycles, one bit per cycle).
- Blanks leading zeros and time-multiplexes the four anodes from a free-running refresh counter.
- Sits directly downstream of the score output, in the top level beside the display controller.

---
 rtl/score_ssd_driver.sv | 158 +++++++++++++++
 tb/tb_score_ssd_driver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_ssd_driver.sv
// Score display driver: binary score -> BCD (shift-and-add-3),
// leading-zero blanking and 4-digit common-anode multiplexing.
module score_ssd_driver #(
  parameter int          REFRESH_BITS = 18,
  parameter logic [15:0] MAX_SHOWN    = 16'd9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] score,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] bcd,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t            state;
  logic [15:0]       sat;
  logic [15:0]       shift_reg;
  logic [15:0]       bcd_work;
  logic [15:0]       conv_val;
  logic [15:0]       last_score;
  logic [3:0]        bit_cnt;
  logic [31:0]       stage;
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]        digit;
  logic [3:0]        nib;
  logic              blank;
  logic [3:0]        an_nxt;
  logic [6:0]        seg_nxt;

  assign sat = (score > MAX_SHOWN) ? MAX_SHOWN : score;
  assign dp  = 1'b1;

  function automatic logic [15:0] add3(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Correct every BCD digit first, then shift the whole pair left.
  assign stage = {add3(bcd_work), shift_reg} << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bcd_work   <= '0;
      conv_val   <= '0;
      last_score <= '0;
      bit_cnt    <= '0;
      bcd        <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sat != last_score) begin
            shift_reg <= sat;
            conv_val  <= sat;
            bcd_work  <= '0;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_work  <= stage[31:16];
          shift_reg <= stage[15:0];
          bit_cnt   <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15)
            state <= COMMIT;
        end
        COMMIT: begin
          bcd        <= bcd_work;
          last_score <= conv_val;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digit = refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    unique case (1'b1)
      digit == 2'd3: begin
        nib   = bcd[15:12];
        blank = (bcd[15:12] == 4'd0);
      end
      digit == 2'd2: begin
        nib   = bcd[11:8];
        blank = (bcd[15:8] == 8'd0);
      end
      digit == 2'd1: begin
        nib   = bcd[7:4];
        blank = (bcd[15:4] == 12'd0);
      end
      default: begin
        nib   = bcd[3:0];
        blank = 1'b0;
      end
    endcase
  end

  always_comb begin
    an_nxt  = ~(4'b0001 << digit);
    seg_nxt = seg_of(nib);
    if (blank) begin
      an_nxt  = 4'b1111;
      seg_nxt = 7'b1111111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh <= '0;
      an      <= 4'b1111;
      seg     <= 7'b1111111;
    end else begin
      refresh <= refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      an      <= an_nxt;
      seg     <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_score_ssd_driver.sv
// Bench for score_ssd_driver: decimal reference model, vector table,
// hand-written corner sequences and randomized score bursts.
module tb_score_ssd_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] score = 16'd0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [15:0] bcd;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  score_ssd_driver #(
    .REFRESH_BITS(4),
    .MAX_SHOWN(16'd9999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .score(score),
    .an(an),
    .seg(seg),
    .dp(dp),
    .bcd(bcd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG_LUT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  function automatic int sat_of(input int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Reference model: decimal value, conversion countdown, scan slot.
  int         m_val = 0;
  int         m_last = 0;
  int         m_pend = 0;
  int         m_left = 0;
  int         m_cnt = 0;
  logic       m_busy = 1'b0;
  logic [3:0] m_an = 4'b1111;
  logic [6:0] m_seg = 7'b1111111;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_val = 0; m_last = 0; m_pend = 0; m_left = 0; m_cnt = 0;
      m_busy = 1'b0; m_an = 4'b1111; m_seg = 7'b1111111;
    end else begin
      int d;
      int dig;
      bit blk;
      d = m_cnt / 4;
      case (d)
        3: begin dig = m_val / 1000;      blk = (m_val < 1000); end
        2: begin dig = (m_val / 100) % 10; blk = (m_val < 100); end
        1: begin dig = (m_val / 10) % 10;  blk = (m_val < 10); end
        default: begin dig = m_val % 10;   blk = 1'b0; end
      endcase
      m_an  = blk ? 4'b1111 : ~(4'b0001 << d);
      m_seg = blk ? 7'b1111111 : SEG_LUT[dig];
      m_cnt = (m_cnt + 1) % 16;
      if (m_left == 0) begin
        if (sat_of(int'(score)) != m_last) begin
          m_pend = sat_of(int'(score));
          m_left = 17;
          m_busy = 1'b1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_val = m_pend;
          m_last = m_pend;
          m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({an, seg, dp, bcd, busy} !==
          {m_an, m_seg, 1'b1, to_bcd(m_val), m_busy}) begin
        failures++;
        $display("FAIL model t=%0t an=%b seg=%b dp=%b bcd=%h busy=%b want an=%b seg=%b dp=1 bcd=%h busy=%b",
                 $time, an, seg, dp, bcd, busy,
                 m_an, m_seg, to_bcd(m_val), m_busy);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic wait_busy(input logic v, input int lim, input string nm);
    int n;
    n = 0;
    while (busy !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    check(nm, {31'd0, busy}, {31'd0, v});
  endtask

  typedef struct {
    logic [15:0] score;
    logic        conv;
    logic [15:0] bcd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n;
    logic [31:0] r;

    tbl[0] = '{16'd1234,  1'b1, 16'h1234};
    tbl[1] = '{16'd7,     1'b1, 16'h0007};
    tbl[2] = '{16'hFFFF,  1'b1, 16'h9999};
    tbl[3] = '{16'd0,     1'b1, 16'h0000};
    tbl[4] = '{16'd10000, 1'b1, 16'h9999};
    tbl[5] = '{16'd9999,  1'b0, 16'h9999};
    tbl[6] = '{16'd100,   1'b1, 16'h0100};
    tbl[7] = '{16'd9,     1'b1, 16'h0009};

    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_bcd", {16'd0, bcd}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    #2 reset = 1'b0;

    // Idle scan of a zero score: only the rightmost digit lights.
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("zero_busy_cnt", n, 0);
    check("zero_an_last", {28'd0, an}, 32'hE);
    check("zero_seg_last", {25'd0, seg}, 32'h01);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      score = tbl[i].score;
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), {31'd0, busy},
            {31'd0, tbl[i].conv});
      if (tbl[i].conv) wait_busy(1'b0, 30, $sformatf("vec%0d_done", i));
      check($sformatf("vec%0d_bcd", i), {16'd0, bcd}, {16'd0, tbl[i].bcd});
      repeat (20) @(negedge clk);
    end

    // Busy width and latency of one conversion.
    score = 16'd4321;
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_width", n, 17);
    check("bcd_4321", {16'd0, bcd}, 32'h4321);
    repeat (16) @(negedge clk);

    // A change while busy is picked up only after the commit.
    score = 16'd1234;
    @(negedge clk);
    check("burst_busy", {31'd0, busy}, 32'h1);
    repeat (3) @(negedge clk);
    score = 16'd5678;
    wait_busy(1'b0, 30, "burst_first_done");
    check("burst_first", {16'd0, bcd}, 32'h1234);
    @(negedge clk);
    check("burst_restart", {31'd0, busy}, 32'h1);
    wait_busy(1'b0, 30, "burst_second_done");
    check("burst_second", {16'd0, bcd}, 32'h5678);
    repeat (16) @(negedge clk);

    // Reset half way through a conversion.
    score = 16'd2222;
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'h1);
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_bcd", {16'd0, bcd}, 32'h0);
    check("mid_rst_busy", {31'd0, busy}, 32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    wait_busy(1'b1, 5, "mid_reconv_start");
    wait_busy(1'b0, 30, "mid_reconv_done");
    check("mid_reconv_bcd", {16'd0, bcd}, 32'h2222);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = $urandom;
      if ($urandom_range(0, 3) == 0) score = 16'($urandom_range(0, 120));
      else score = r[15:0];
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end
    wait_busy(1'b0, 40, "final_idle");
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
